// File: rtl/sram_ctrl.sv
// sram_ctrl: bus-side initiator for the sim_ram SRAM model.
//
// Accepts read/write commands on a valid/ready channel, drives the SRAM pins
// combinationally from an accepted legal command, captures ram_dout one cycle
// later and queues the response in a 2-entry FIFO whose head register drives
// the response channel. Credit-based cmd_ready guarantees a free FIFO slot for
// every in-flight command, so read data is never dropped under backpressure.
//
// Optional feature macro: SRAM_CTRL_ADDR_CHK_EN
//   defined   : out-of-range word index, or a misaligned full-mask write, is
//               rejected (no SRAM access, rsp_err = 1, rsp_rdata = 0).
//   undefined : word index wraps to log2(DP) bits, every command is legal,
//               rsp_err is always 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_read, cmd_addr              1 = read / 0 = write, byte address
//   cmd_wdata, cmd_wmask            write data and byte enables
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              read data (0 for writes/errors), error flag
//   ram_addr, ram_din, ram_we,      SRAM word address, write data, write
//   ram_wem, ram_dout               enable, write mask, read data
module sram_ctrl #(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    localparam int OW = $clog2(MW);
    localparam int IW = $clog2(DP);

    logic [AW-1:0] word_idx;
    logic [AW-1:0] ram_idx;
    logic          legal;
    logic          accept;
    logic          acc_legal;

    logic [AW-1:0] last_rd_addr;
    logic          pend;
    logic          pend_read;
    logic          pend_err;

    logic [1:0]    cnt;
    logic [DW-1:0] ent1_data;
    logic          ent1_err;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic [2:0]    credit;

    assign word_idx = cmd_addr >> OW;

`ifdef SRAM_CTRL_ADDR_CHK_EN
    assign legal   = (word_idx < AW'(DP)) &&
                     !(!cmd_read && (&cmd_wmask) && (cmd_addr[OW-1:0] != '0));
    assign ram_idx = word_idx;
`else
    logic addr_unused;
    assign legal       = 1'b1;
    assign ram_idx     = AW'(word_idx[IW-1:0]);
    assign addr_unused = ^{word_idx[AW-1:IW], cmd_addr[OW-1:0]};
`endif

    // Outstanding = queued + in flight, minus the entry leaving this cycle.
    assign pop       = rsp_valid & rsp_ready;
    assign push      = pend;
    assign credit    = {1'b0, cnt} + 3'(pend) - 3'(pop);
    assign cmd_ready = (credit < 3'd2);

    assign accept    = cmd_valid & cmd_ready;
    assign acc_legal = accept & legal;

    // When idle the SRAM still latches ram_addr, so park it on the last read
    // address to keep ram_dout stable.
    always_comb begin
        ram_addr = last_rd_addr;
        ram_din  = '0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        if (acc_legal) begin
            ram_addr = ram_idx;
            ram_din  = cmd_wdata;
            ram_we   = ~cmd_read;
            ram_wem  = cmd_wmask;
        end
    end

    assign push_data = (pend_read && !pend_err) ? ram_dout : '0;
    assign rsp_valid = (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_addr <= '0;
            pend         <= 1'b0;
            pend_read    <= 1'b0;
            pend_err     <= 1'b0;
        end else begin
            pend      <= accept;
            pend_read <= cmd_read;
            pend_err  <= ~legal;
            if (acc_legal && cmd_read) begin
                last_rd_addr <= ram_idx;
            end
        end
    end

    // Shift-register FIFO: rsp_rdata/rsp_err are the head entry itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ent1_data <= '0;
            ent1_err  <= 1'b0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            if (pop) begin
                if (cnt == 2'd2) begin
                    rsp_rdata <= ent1_data;
                    rsp_err   <= ent1_err;
                end else if (push) begin
                    rsp_rdata <= push_data;
                    rsp_err   <= pend_err;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    rsp_rdata <= push_data;
                    rsp_err   <= pend_err;
                end else begin
                    ent1_data <= push_data;
                    ent1_err  <= pend_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
    localparam int DP = 512;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_dout;
    logic          mem_clr;

    sram_ctrl #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_wem(ram_wem), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // SRAM: masked write, otherwise latch address; one-cycle read latency.
    logic [DW-1:0] ram_mem [DP];
    logic [DW-1:0] ram_q;
    assign ram_dout = ram_q;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DP; i++) ram_mem[i] <= '0;
            ram_q <= '0;
        end else if (ram_we) begin
            for (int b = 0; b < MW; b++)
                if (ram_wem[b]) ram_mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
        end else begin
            ram_q <= ram_mem[ram_addr[8:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: word memory, ordered list of owed responses with the
    // cycle each becomes visible, and the parked read address.
    typedef struct { logic [31:0] data; logic err; int vis; } exp_t;
    typedef struct { logic [31:0] data; logic err; int cyc; } got_t;
    exp_t          exp_q[$];
    got_t          got_q[$];
    logic [31:0]   mdl_mem [DP];
    logic [31:0]   mdl_last;

    always @(negedge clk) begin
        logic        acc, legal, exp_valid, pop;
        logic [31:0] idx, eaddr;
        exp_t        e;
        if (mem_clr) begin
            for (int i = 0; i < DP; i++) mdl_mem[i] = '0;
        end
        if (!rst_n) begin
            exp_q.delete();
            mdl_last = '0;
        end else begin
            acc = cmd_valid & cmd_ready;
            idx = cmd_addr / 4;
`ifdef SRAM_CTRL_ADDR_CHK_EN
            legal = (idx < DP) && !(!cmd_read && cmd_wmask == 4'hF && (cmd_addr % 4) != 0);
            eaddr = idx;
`else
            legal = 1'b1;
            eaddr = idx % DP;
`endif
            exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            chk1("rsp_valid", rsp_valid, exp_valid);
            pop = exp_valid & rsp_ready;
            chk1("cmd_ready", cmd_ready, (exp_q.size() - int'(pop)) < 2);
            if (exp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].data);
                chk1("rsp_err", rsp_err, exp_q[0].err);
            end
            if (acc && legal) begin
                chk("ram_addr", ram_addr, eaddr);
                chk1("ram_we", ram_we, !cmd_read);
                chk("ram_wem", 32'(ram_wem), 32'(cmd_wmask));
                chk("ram_din", ram_din, cmd_wdata);
            end else begin
                chk("ram_addr_idle", ram_addr, mdl_last);
                chk1("ram_we_idle", ram_we, 1'b0);
                chk("ram_wem_idle", 32'(ram_wem), 32'd0);
            end
            if (pop) begin
                got_q.push_back('{rsp_rdata, rsp_err, cyc});
                void'(exp_q.pop_front());
            end
            if (acc) begin
                e.vis = cyc + 2;
                e.data = '0;
                e.err = !legal;
                if (legal && cmd_read) begin
                    e.data = mdl_mem[eaddr];
                    mdl_last = eaddr;
                end else if (legal) begin
                    for (int b = 0; b < 4; b++)
                        if (cmd_wmask[b]) mdl_mem[eaddr][8*b +: 8] = cmd_wdata[8*b +: 8];
                end
                exp_q.push_back(e);
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int acc_cyc);
        int b;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_wmask = m;
        b = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!cmd_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (cmd_ready) acc_cyc = cyc;
        else begin
            tests++; fails++;
            $display("FAIL send_timeout: addr %h never accepted", a);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int b;
        b = 0;
        while (got_q.size() < n && b < 50) begin
            @(posedge clk);
            b++;
        end
        #1;
        tests++;
        if (got_q.size() < n) begin
            fails++;
            $display("FAIL wait_rsp: got %0d responses expected %0d", got_q.size(), n);
        end
    endtask

    initial begin
        int ac, dummy;
        rst_n = 1'b0; mem_clr = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_wem", 32'(ram_wem), 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        mem_clr = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // write then read, latency 2
        send(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, dummy);
        send(1'b1, 32'h10, 32'h0, 4'h0, ac);
        wait_got(2);
        if (got_q.size() >= 2) begin
            chk("wr_ack_data", got_q[0].data, 32'h0);
            chk("rd_data_10", got_q[1].data, 32'hDEADBEEF);
            chk("rd_latency", 32'(got_q[1].cyc - ac), 32'd2);
        end
        got_q.delete();

        // partial mask write
        send(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, dummy);
        send(1'b0, 32'h20, 32'h00000000, 4'h2, dummy);
        send(1'b1, 32'h20, 32'h0, 4'h0, dummy);
        wait_got(3);
        if (got_q.size() >= 3) chk("rd_mask_20", got_q[2].data, 32'hFFFF00FF);
        got_q.delete();

        // backpressure
        send(1'b0, 32'h0, 32'd1, 4'hF, dummy);
        send(1'b0, 32'h4, 32'd2, 4'hF, dummy);
        send(1'b0, 32'h8, 32'd3, 4'hF, dummy);
        wait_got(3);
        got_q.delete();
        rsp_ready = 1'b0;
        send(1'b1, 32'h0, 32'h0, 4'h0, dummy);
        send(1'b1, 32'h4, 32'h0, 4'h0, dummy);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h8;
        repeat (3) begin
            @(negedge clk);
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(1'b1, 32'h8, 32'h0, 4'h0, dummy);
        wait_got(3);
        if (got_q.size() >= 3) begin
            chk("bp_rsp0", got_q[0].data, 32'd1);
            chk("bp_rsp1", got_q[1].data, 32'd2);
            chk("bp_rsp2", got_q[2].data, 32'd3);
        end
        got_q.delete();

        // parked address while backpressured
        send(1'b0, 32'h40, 32'h12345678, 4'hF, dummy);
        wait_got(1);
        got_q.delete();
        rsp_ready = 1'b0;
        send(1'b1, 32'h40, 32'h0, 4'h0, dummy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ram_addr", ram_addr, 32'h10);
            if (i >= 1) chk("hold_rsp_rdata", rsp_rdata, 32'h12345678);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_got(1);
        got_q.delete();

        // out-of-range read
        send(1'b1, 32'(4 * DP), 32'h0, 4'h0, dummy);
        wait_got(1);
        if (got_q.size() >= 1) begin
`ifdef SRAM_CTRL_ADDR_CHK_EN
            chk("oor_rdata", got_q[0].data, 32'h0);
            chk1("oor_err", got_q[0].err, 1'b1);
`else
            chk("oor_rdata", got_q[0].data, 32'd1);
            chk1("oor_err", got_q[0].err, 1'b0);
`endif
        end
        got_q.delete();

        // asynchronous reset with two queued responses
        rsp_ready = 1'b0;
        send(1'b1, 32'h4, 32'h0, 4'h0, dummy);
        send(1'b1, 32'h8, 32'h0, 4'h0, dummy);
        repeat (2) @(posedge clk);
        #1;
        chk1("pre_rst_valid", rsp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", rsp_valid, 1'b0);
        chk1("async_rst_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_ready", cmd_ready, 1'b1);
        send(1'b1, 32'h8, 32'h0, 4'h0, dummy);
        wait_got(1);
        if (got_q.size() >= 1) chk("post_rst_rd", got_q[0].data, 32'd3);
        got_q.delete();

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 1500; n++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_read  = 1'($urandom_range(0, 1));
            cmd_addr  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 127))
                                                   : 32'($urandom_range(0, 4 * DP + 63));
            cmd_wdata = $urandom;
            cmd_wmask = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk1("drain_valid", rsp_valid, 1'b0);
        got_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
